// File: rtl/coincidence_auto_aligner_pkg.sv
// Shared constants, CSR word layouts and FSM states for the coincidence auto-aligner.
package coincidence_auto_aligner_pkg;

  localparam int unsigned ADDR_W          = 24;
  localparam int unsigned CHAN_W          = 8;
  localparam int unsigned CSR_W           = 32;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned EDGE_CNT_W      = 16;
  localparam int unsigned CSR_ACQ_BIT     = 31;
  localparam int unsigned CSR_SETOFF_BIT  = 30;
  localparam int unsigned CSR_REALIGN_BIT = 29;
  localparam int unsigned HOLD_CLKS       = 8;

  // Histogram read request: channel in the top byte, bin address below.
  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [ADDR_W-1:0] addr;
  } csr_read_t;

  // Offset write: command bits, reserved gap, offset value.
  typedef struct packed {
    logic [2:0]        cmd;
    logic [4:0]        rsvd;
    logic [ADDR_W-1:0] off;
  } csr_offset_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACQ,
    ST_ACQ_HOLD,
    ST_POLL,
    ST_SCAN_REQ,
    ST_SETTLE,
    ST_EVAL,
    ST_WRAP,
    ST_RESULT,
    ST_WR_OFF,
    ST_WR_REALIGN,
    ST_DONE
  } state_e;

  // Single-bit command word (acquire / realign).
  function automatic logic [CSR_W-1:0] csr_cmd_word(input int unsigned bit_pos);
    csr_cmd_word = CSR_W'(1) << bit_pos;
  endfunction

  function automatic logic [CSR_W-1:0] csr_read_word(input logic [CHAN_W-1:0] chan,
                                                     input logic [ADDR_W-1:0] addr);
    csr_read_t w;
    w.chan = chan;
    w.addr = addr;
    csr_read_word = w;
  endfunction

  function automatic logic [CSR_W-1:0] csr_offset_word(input logic [ADDR_W-1:0] off);
    csr_offset_t w;
    w.cmd  = 3'b010;
    w.rsvd = 5'd0;
    w.off  = off;
    csr_offset_word = w;
  endfunction

endpackage

// File: rtl/coincidence_auto_aligner_edge_tracker.sv
// Tracks previous/first bin level, detects the selected edge (including the wrap pair)
// and keeps the last edge index plus a saturating edge count.
module coincidence_auto_aligner_edge_tracker
  import coincidence_auto_aligner_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  falling_i,
  input  logic                  eval_i,
  input  logic                  first_i,
  input  logic                  wrap_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  high_i,
  output logic [ADDR_W-1:0]     edge_index_o,
  output logic [EDGE_CNT_W-1:0] edge_count_o
);

  logic                  p_q, p_d;
  logic                  h0_q, h0_d;
  logic [ADDR_W-1:0]     index_q, index_d;
  logic [EDGE_CNT_W-1:0] count_q, count_d;
  logic                  cur_h_c;
  logic                  compare_c;
  logic                  edge_c;

  // Edge detection and next-state for the tracker registers.
  always_comb begin
    p_d       = p_q;
    h0_d      = h0_q;
    index_d   = index_q;
    count_d   = count_q;
    cur_h_c   = wrap_i ? h0_q : high_i;
    compare_c = wrap_i | (eval_i & ~first_i);
    edge_c    = compare_c & (falling_i ? (~cur_h_c & p_q) : (cur_h_c & ~p_q));
    if (clear_i) begin
      p_d     = 1'b0;
      h0_d    = 1'b0;
      index_d = '0;
      count_d = '0;
    end else begin
      if (eval_i) begin
        p_d = high_i;
        if (first_i) h0_d = high_i;
      end
      if (edge_c) begin
        index_d = wrap_i ? '0 : addr_i;
        if (count_q != {EDGE_CNT_W{1'b1}}) count_d = count_q + EDGE_CNT_W'(1);
      end
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q     <= 1'b0;
      h0_q    <= 1'b0;
      index_q <= '0;
      count_q <= '0;
    end else begin
      p_q     <= p_d;
      h0_q    <= h0_d;
      index_q <= index_d;
      count_q <= count_d;
    end
  end

  assign edge_index_o = index_q;
  assign edge_count_o = count_q;

endmodule

// File: rtl/coincidence_auto_aligner.sv
// Drives a coincidence recorder CSR through acquire, histogram scan, edge search
// and offset/realign writes, replacing the software alignment loop.
module coincidence_auto_aligner
  import coincidence_auto_aligner_pkg::*;
#(
  parameter int unsigned BINS          = 400,
  parameter int unsigned CHANNEL_COUNT = 2,
  parameter int unsigned DATA_WIDTH    = 3,
  parameter int unsigned THRESHOLD     = 1,
  parameter int unsigned EDGE_ADVANCE  = 2,
  parameter int unsigned SETTLE_CLKS   = 16,
  parameter int unsigned ACQ_TIMEOUT   = 1048576,
  parameter int unsigned AUTO_REALIGN  = 1
) (
  input  logic        sysClk,
  input  logic        sysReset,
  input  logic        start,
  input  logic [7:0]  chan,
  input  logic        fallingEdge,
  output logic        busy,
  output logic        done,
  output logic [23:0] edgeIndex,
  output logic [15:0] edgeCount,
  output logic [1:0]  fault,
  output logic        recStrobe,
  output logic [31:0] recGPIO_OUT,
  input  logic [31:0] recCsr
);

  localparam int unsigned SUM_W = ADDR_W + 2;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAN_W-1:0]    chan_q, chan_d;
  logic                 falling_q, falling_d;
  logic [1:0]           fault_q, fault_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 strobe_q, strobe_d;
  logic [CSR_W-1:0]     wdata_q, wdata_d;

  logic                 accept_c;
  logic                 high_c;
  logic                 rec_busy_c;
  logic [SUM_W-1:0]     off_sum_c;
  logic [ADDR_W-1:0]    off_c;
  logic [ADDR_W-1:0]    edge_index_w;
  logic [EDGE_CNT_W-1:0] edge_count_w;
  logic                 unused_csr_c;

  assign high_c       = recCsr[DATA_WIDTH-1:0] >= DATA_WIDTH'(THRESHOLD);
  assign rec_busy_c   = recCsr[CSR_ACQ_BIT];
  assign unused_csr_c = ^recCsr[CSR_W-2:DATA_WIDTH];

  // Offset = edge - advance, wrapped into [0, BINS) without underflow.
  always_comb begin
    off_sum_c = SUM_W'(edge_index_w) + SUM_W'(BINS) - SUM_W'(EDGE_ADVANCE);
    if (off_sum_c >= SUM_W'(BINS)) off_sum_c = off_sum_c - SUM_W'(BINS);
    off_c = ADDR_W'(off_sum_c);
  end

  coincidence_auto_aligner_edge_tracker u_edge_tracker (
    .clk_i        (sysClk),
    .rst_i        (sysReset),
    .clear_i      (accept_c),
    .falling_i    (falling_q),
    .eval_i       (state_q == ST_EVAL),
    .first_i      (addr_q == '0),
    .wrap_i       (state_q == ST_WRAP),
    .addr_i       (addr_q),
    .high_i       (high_c),
    .edge_index_o (edge_index_w),
    .edge_count_o (edge_count_w)
  );

  // Sequencer next-state, timers and CSR write mux.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    falling_d = falling_q;
    fault_d   = fault_q;
    strobe_d  = 1'b0;
    wdata_d   = '0;
    accept_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          chan_d    = chan;
          falling_d = fallingEdge;
          addr_d    = '0;
          cnt_d     = '0;
          if (32'(chan) >= CHANNEL_COUNT) begin
            fault_d = 2'b01;
            state_d = ST_DONE;
          end else begin
            fault_d  = 2'b00;
            state_d  = ST_ACQ;
            strobe_d = 1'b1;
            wdata_d  = csr_cmd_word(CSR_ACQ_BIT);
          end
        end
      end
      ST_ACQ: begin
        cnt_d   = '0;
        state_d = ST_ACQ_HOLD;
      end
      ST_ACQ_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CLKS - 1)) begin
          cnt_d   = '0;
          state_d = ST_POLL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_POLL: begin
        if (!rec_busy_c) begin
          state_d  = ST_SCAN_REQ;
          strobe_d = 1'b1;
          wdata_d  = csr_read_word(chan_q, addr_q);
        end else if (cnt_q == CNT_W'(ACQ_TIMEOUT - 1)) begin
          fault_d = 2'b10;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SCAN_REQ: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CLKS - 1)) begin
          state_d = ST_EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        if (addr_q == ADDR_W'(BINS - 1)) begin
          state_d = ST_WRAP;
        end else begin
          addr_d   = addr_q + ADDR_W'(1);
          state_d  = ST_SCAN_REQ;
          strobe_d = 1'b1;
          wdata_d  = csr_read_word(chan_q, addr_d);
        end
      end
      ST_WRAP: begin
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (edge_count_w == '0) begin
          fault_d = 2'b01;
          state_d = ST_DONE;
        end else begin
          state_d  = ST_WR_OFF;
          strobe_d = 1'b1;
          wdata_d  = csr_offset_word(off_c);
        end
      end
      ST_WR_OFF: begin
        if (AUTO_REALIGN != 0) begin
          state_d  = ST_WR_REALIGN;
          strobe_d = 1'b1;
          wdata_d  = csr_cmd_word(CSR_REALIGN_BIT);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WR_REALIGN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // Sequencer registers; reset aborts any sequence with no further writes.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      chan_q    <= '0;
      falling_q <= 1'b0;
      fault_q   <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      strobe_q  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      chan_q    <= chan_d;
      falling_q <= falling_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      strobe_q  <= strobe_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign edgeIndex   = edge_index_w;
  assign edgeCount   = edge_count_w;
  assign fault       = fault_q;
  assign recStrobe   = strobe_q;
  assign recGPIO_OUT = wdata_q;

endmodule

// File: tb/tb_coincidence_auto_aligner.sv
// Directed bench for coincidence_auto_aligner with a behavioural recorder model.
module tb_coincidence_auto_aligner;

  localparam int NBINS    = 400;
  localparam int BUSY_LEN = 20;
  localparam int BOUND    = 5000;

  logic        sysClk = 1'b0;
  logic        sysReset;
  logic        start;
  logic [7:0]  chan;
  logic        fallingEdge;
  logic        busy;
  logic        done;
  logic [23:0] edgeIndex;
  logic [15:0] edgeCount;
  logic [1:0]  fault;
  logic        recStrobe;
  logic [31:0] recGPIO_OUT;
  logic [31:0] recCsr;

  int n_checks = 0;
  int n_fail   = 0;

  // Recorder model state
  logic [2:0]  hist [0:1][0:NBINS-1];
  int          busy_cnt = 0;
  logic        busy_stuck = 1'b0;
  int          rd_addr = 0;
  int          rd_chan = 0;
  logic [2:0]  rd_val;
  int          n_acq, n_read, n_off, n_realign, n_other, first_read;
  logic [31:0] last_w, prev_w;

  always #5 sysClk = ~sysClk;

  coincidence_auto_aligner #(
    .BINS(400), .CHANNEL_COUNT(2), .DATA_WIDTH(3), .THRESHOLD(1), .EDGE_ADVANCE(2),
    .SETTLE_CLKS(4), .ACQ_TIMEOUT(1000), .AUTO_REALIGN(1)
  ) dut (
    .sysClk(sysClk), .sysReset(sysReset), .start(start), .chan(chan),
    .fallingEdge(fallingEdge), .busy(busy), .done(done), .edgeIndex(edgeIndex),
    .edgeCount(edgeCount), .fault(fault), .recStrobe(recStrobe),
    .recGPIO_OUT(recGPIO_OUT), .recCsr(recCsr)
  );

  always_comb begin
    rd_val = 3'd0;
    if (rd_chan < 2 && rd_addr < NBINS) rd_val = hist[rd_chan][rd_addr];
  end
  assign recCsr = {busy_stuck | (busy_cnt != 0), 28'd0, rd_val};

  // Recorder: decode CSR writes, run the busy timer, latch read address.
  always @(posedge sysClk) begin
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (!recStrobe && recGPIO_OUT != 32'd0) n_other = n_other + 1;
    if (recStrobe) begin
      prev_w = last_w;
      last_w = recGPIO_OUT;
      if (recGPIO_OUT == 32'h8000_0000) begin
        n_acq = n_acq + 1;
        busy_cnt = BUSY_LEN;
      end else if (recGPIO_OUT == 32'h2000_0000) begin
        n_realign = n_realign + 1;
      end else if (recGPIO_OUT[31:24] == 8'h40) begin
        n_off = n_off + 1;
      end else if (recGPIO_OUT[31:29] == 3'b000) begin
        if (n_read == 0) first_read = int'(recGPIO_OUT[23:0]);
        n_read  = n_read + 1;
        rd_addr = int'(recGPIO_OUT[23:0]);
        rd_chan = int'(recGPIO_OUT[31:24]);
      end else begin
        n_other = n_other + 1;
      end
    end
  end

  task automatic clear_log();
    n_acq = 0; n_read = 0; n_off = 0; n_realign = 0; n_other = 0;
    first_read = -1; last_w = 32'd0; prev_w = 32'd0;
  endtask

  task automatic clear_hist();
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < NBINS; b++) hist[c][b] = 3'd0;
  endtask

  task automatic set_hist(input int c, input int lo, input int hi, input logic [2:0] v);
    for (int b = lo; b <= hi; b++) hist[c][b] = v;
  endtask

  // Pulse start, optionally re-pulse at cycle second_at, wait for done (bounded).
  task automatic run_scan(input logic [7:0] ch, input logic fe, input int second_at,
                          output int cyc, output logic timed_out);
    int c;
    @(negedge sysClk);
    chan = ch; fallingEdge = fe; start = 1'b1;
    @(negedge sysClk);
    start = 1'b0;
    timed_out = 1'b1;
    for (c = 0; c < BOUND; c++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      start = (c == second_at);
      if (c == second_at) begin
        chan = 8'd1; fallingEdge = ~fe;
      end
      @(negedge sysClk);
    end
    start = 1'b0;
    cyc = c;
  endtask

  task automatic test_reset();
    sysReset = 1'b1; start = 1'b0; chan = 8'd0; fallingEdge = 1'b0;
    clear_log();
    repeat (3) @(negedge sysClk);
    n_checks++; if ({busy, done, edgeIndex, edgeCount, fault} !== 44'd0) begin n_fail++; $display("FAIL reset_status: got %0h expected 0", {busy, done, edgeIndex, edgeCount, fault}); end
    n_checks++; if ({recStrobe, recGPIO_OUT} !== 33'd0) begin n_fail++; $display("FAIL reset_csr: got %0h expected 0", {recStrobe, recGPIO_OUT}); end
    sysReset = 1'b0;
    repeat (2) @(negedge sysClk);
    n_checks++; if ({busy, done, fault, recStrobe} !== 5'd0) begin n_fail++; $display("FAIL idle_after_reset: got %0h expected 0", {busy, done, fault, recStrobe}); end
  endtask

  task automatic test_basic_rising();
    int cyc; logic to;
    clear_hist(); set_hist(0, 120, 180, 3'd5); hist[0][120] = 3'd1;
    clear_log();
    run_scan(8'd0, 1'b0, -1, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_done: timed out after %0d cycles, expected done", cyc); end
    n_checks++; if (edgeIndex !== 24'd120) begin n_fail++; $display("FAIL basic_index: got %0d expected 120", edgeIndex); end
    n_checks++; if (edgeCount !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", edgeCount); end
    n_checks++; if (fault !== 2'b00) begin n_fail++; $display("FAIL basic_fault: got %b expected 00", fault); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    n_checks++; if (n_acq !== 1 || n_read !== NBINS) begin n_fail++; $display("FAIL basic_writes: acq %0d read %0d expected 1 400", n_acq, n_read); end
    n_checks++; if (prev_w !== 32'h4000_0076) begin n_fail++; $display("FAIL basic_offset_word: got %h expected 40000076", prev_w); end
    n_checks++; if (last_w !== 32'h2000_0000 || n_realign !== 1) begin n_fail++; $display("FAIL basic_realign: got %h x%0d expected 20000000 x1", last_w, n_realign); end
    n_checks++; if (n_other !== 0) begin n_fail++; $display("FAIL basic_stray_data: got %0d expected 0", n_other); end
    @(negedge sysClk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_wrap();
    int cyc; logic to;
    clear_hist(); set_hist(0, 398, 399, 3'd3); set_hist(0, 0, 10, 3'd3);
    clear_log();
    run_scan(8'd0, 1'b0, -1, cyc, to);
    n_checks++; if (to !== 1'b0 || edgeIndex !== 24'd398 || edgeCount !== 16'd1) begin n_fail++; $display("FAIL wrap_rising: to %b index %0d count %0d expected 0 398 1", to, edgeIndex, edgeCount); end
    n_checks++; if (prev_w !== 32'h4000_018C) begin n_fail++; $display("FAIL wrap_rising_offset: got %h expected 4000018c", prev_w); end
    clear_log();
    run_scan(8'd0, 1'b1, -1, cyc, to);
    n_checks++; if (to !== 1'b0 || edgeIndex !== 24'd11 || edgeCount !== 16'd1) begin n_fail++; $display("FAIL wrap_falling: to %b index %0d count %0d expected 0 11 1", to, edgeIndex, edgeCount); end
    n_checks++; if (prev_w !== 32'h4000_0009) begin n_fail++; $display("FAIL wrap_falling_offset: got %h expected 40000009", prev_w); end
  endtask

  task automatic test_edge_bin1();
    int cyc; logic to;
    clear_hist(); set_hist(0, 1, 5, 3'd7);
    clear_log();
    run_scan(8'd0, 1'b0, -1, cyc, to);
    n_checks++; if (to !== 1'b0 || edgeIndex !== 24'd1) begin n_fail++; $display("FAIL bin1_index: to %b index %0d expected 0 1", to, edgeIndex); end
    n_checks++; if (prev_w !== 32'h4000_018F) begin n_fail++; $display("FAIL bin1_offset: got %h expected 4000018f", prev_w); end
  endtask

  task automatic test_edge_at_zero();
    int cyc; logic to;
    clear_hist(); set_hist(0, 0, 9, 3'd2);
    clear_log();
    run_scan(8'd0, 1'b0, -1, cyc, to);
    n_checks++; if (to !== 1'b0 || edgeIndex !== 24'd0 || edgeCount !== 16'd1) begin n_fail++; $display("FAIL zero_wrap_edge: to %b index %0d count %0d expected 0 0 1", to, edgeIndex, edgeCount); end
    n_checks++; if (prev_w !== 32'h4000_018E) begin n_fail++; $display("FAIL zero_wrap_offset: got %h expected 4000018e", prev_w); end
  endtask

  task automatic test_two_edges();
    int cyc; logic to;
    clear_hist(); set_hist(1, 50, 60, 3'd4); set_hist(1, 300, 310, 3'd4);
    clear_log();
    run_scan(8'd1, 1'b0, -1, cyc, to);
    n_checks++; if (to !== 1'b0 || edgeIndex !== 24'd300) begin n_fail++; $display("FAIL two_edges_index: to %b index %0d expected 0 300", to, edgeIndex); end
    n_checks++; if (edgeCount !== 16'd2 || fault !== 2'b00) begin n_fail++; $display("FAIL two_edges_count: count %0d fault %b expected 2 00", edgeCount, fault); end
    n_checks++; if (prev_w !== 32'h4000_012A) begin n_fail++; $display("FAIL two_edges_offset: got %h expected 4000012a", prev_w); end
  endtask

  task automatic test_no_edge();
    int cyc; logic to;
    for (int pass = 0; pass < 2; pass++) begin
      clear_hist();
      if (pass == 1) set_hist(0, 0, NBINS - 1, 3'd7);
      clear_log();
      run_scan(8'd0, 1'b0, -1, cyc, to);
      n_checks++; if (to !== 1'b0 || fault !== 2'b01 || edgeCount !== 16'd0) begin n_fail++; $display("FAIL no_edge_fault[%0d]: to %b fault %b count %0d expected 0 01 0", pass, to, fault, edgeCount); end
      n_checks++; if (n_acq !== 1 || n_read !== NBINS || n_off !== 0 || n_realign !== 0) begin n_fail++; $display("FAIL no_edge_writes[%0d]: acq %0d read %0d off %0d realign %0d expected 1 400 0 0", pass, n_acq, n_read, n_off, n_realign); end
    end
  endtask

  task automatic test_timeout();
    int cyc; logic to;
    clear_hist(); set_hist(0, 120, 180, 3'd5);
    busy_stuck = 1'b1;
    clear_log();
    run_scan(8'd0, 1'b0, -1, cyc, to);
    busy_stuck = 1'b0;
    n_checks++; if (to !== 1'b0 || fault !== 2'b10) begin n_fail++; $display("FAIL timeout_fault: to %b fault %b expected 0 10", to, fault); end
    n_checks++; if (cyc < 1000 || cyc > 1030) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles expected 1000..1030", cyc); end
    n_checks++; if (n_acq !== 1 || n_read !== 0 || n_off !== 0) begin n_fail++; $display("FAIL timeout_writes: acq %0d read %0d off %0d expected 1 0 0", n_acq, n_read, n_off); end
  endtask

  task automatic test_bad_chan();
    int cyc; logic to;
    clear_log();
    run_scan(8'd5, 1'b0, -1, cyc, to);
    n_checks++; if (to !== 1'b0 || cyc > 2 || fault !== 2'b01) begin n_fail++; $display("FAIL bad_chan: to %b cycles %0d fault %b expected 0 <=2 01", to, cyc, fault); end
    n_checks++; if (n_acq + n_read + n_off + n_realign + n_other !== 0) begin n_fail++; $display("FAIL bad_chan_writes: got %0d expected 0", n_acq + n_read + n_off + n_realign + n_other); end
  endtask

  task automatic test_start_while_busy();
    int cyc; logic to;
    clear_hist(); set_hist(0, 120, 180, 3'd5);
    clear_log();
    run_scan(8'd0, 1'b0, 50, cyc, to);
    n_checks++; if (to !== 1'b0 || edgeIndex !== 24'd120 || edgeCount !== 16'd1 || fault !== 2'b00) begin n_fail++; $display("FAIL busy_start_result: to %b index %0d count %0d fault %b expected 0 120 1 00", to, edgeIndex, edgeCount, fault); end
    n_checks++; if (n_acq !== 1 || n_read !== NBINS) begin n_fail++; $display("FAIL busy_start_writes: acq %0d read %0d expected 1 400", n_acq, n_read); end
    repeat (5) @(negedge sysClk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc, total; logic to, found;
    clear_hist(); set_hist(0, 120, 180, 3'd5);
    clear_log();
    @(negedge sysClk);
    chan = 8'd0; fallingEdge = 1'b0; start = 1'b1;
    @(negedge sysClk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < BOUND; c++) begin
      if (n_read == 38 && rd_addr == 37) begin
        found = 1'b1;
        break;
      end
      @(negedge sysClk);
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL midreset_reach_addr37: got reads %0d expected 38", n_read); end
    @(negedge sysClk);
    sysReset = 1'b1;
    @(negedge sysClk);
    sysReset = 1'b0;
    n_checks++; if (busy !== 1'b0 || recStrobe !== 1'b0) begin n_fail++; $display("FAIL midreset_abort: busy %b strobe %b expected 0 0", busy, recStrobe); end
    total = n_acq + n_read + n_off + n_realign;
    repeat (40) @(negedge sysClk);
    n_checks++; if (n_acq + n_read + n_off + n_realign !== total || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet: writes %0d busy %b expected %0d 0", n_acq + n_read + n_off + n_realign, busy, total); end
    clear_log();
    run_scan(8'd0, 1'b0, -1, cyc, to);
    n_checks++; if (to !== 1'b0 || first_read !== 0 || n_read !== NBINS) begin n_fail++; $display("FAIL midreset_rescan: to %b first %0d reads %0d expected 0 0 400", to, first_read, n_read); end
    n_checks++; if (edgeIndex !== 24'd120 || prev_w !== 32'h4000_0076) begin n_fail++; $display("FAIL midreset_result: index %0d offset %h expected 120 40000076", edgeIndex, prev_w); end
  endtask

  initial begin
    test_reset();
    test_basic_rising();
    test_wrap();
    test_edge_bin1();
    test_edge_at_zero();
    test_two_edges();
    test_no_edge();
    test_timeout();
    test_bad_chan();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
